// File: rtl/max7219_rx.sv
// max7219_rx: far-end receiver for the MAX7219 3-wire serial link.
// Oversamples cs_n/sclk/mosi with clk, decodes 16-bit frames and keeps a
// shadow of the MAX7219 register file plus the rebuilt BCD time word.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   spi_cs_n/sclk/mosi   asynchronous serial pins (data sampled on sclk rise)
//   frame_valid/err      one-cycle pulses for accepted / rejected frames
//   frame_addr/data      address and data of the last accepted frame
//   digit_data ...       shadow registers (digits, decode, intensity, ...)
//   time_data            low nibbles of reg8..reg1, combinational
module max7219_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic [63:0] digit_data,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic [31:0] time_data
);

  localparam int unsigned CNT_W      = 5;
  localparam int unsigned FRAME_BITS = 16;
  // Bits 15:12 of a frame are don't-care, so only the low 12 are kept.
  localparam int unsigned KEEP_BITS  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES:0]   vld_q, vld_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [KEEP_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic [3:0]             frame_addr_q, frame_addr_d;
  logic [7:0]             frame_data_q, frame_data_d;
  logic [63:0]            digit_data_q, digit_data_d;
  logic [7:0]             decode_mode_q, decode_mode_d;
  logic [3:0]             intensity_q, intensity_d;
  logic [2:0]             scan_limit_q, scan_limit_d;
  logic                   shutdown_n_q, shutdown_n_d;
  logic                   display_test_q, display_test_d;

  logic       cs_s, sclk_s, mosi_s, pipe_ok;
  logic       cs_fall, cs_rise, sclk_rise;
  logic [3:0] addr;
  logic [7:0] data;
  logic [2:0] digit_idx;

  // Synchronized pins and edge detection. vld tracks which pipeline stages
  // hold real samples since reset, so reset values cannot fake a cs_n fall
  // when reset is released in the middle of a frame.
  always_comb begin
    cs_s      = cs_sync_q[SYNC_STAGES-1];
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    pipe_ok   = vld_q[SYNC_STAGES];
    cs_fall   = pipe_ok & cs_prev_q & ~cs_s;
    cs_rise   = pipe_ok & ~cs_prev_q & cs_s;
    // Gated by the previous cs sample so a sclk edge coincident with the
    // cs_n rise is still shifted in.
    sclk_rise = pipe_ok & ~sclk_prev_q & sclk_s & ~cs_prev_q;
  end

  // Frame decode, next-state and register-map write.
  always_comb begin
    cs_sync_d      = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sclk_sync_d    = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    vld_d          = {vld_q[SYNC_STAGES-1:0], 1'b1};
    cs_prev_d      = cs_s;
    sclk_prev_d    = sclk_s;
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    frame_valid_d  = 1'b0;
    frame_err_d    = 1'b0;
    frame_addr_d   = frame_addr_q;
    frame_data_d   = frame_data_q;
    digit_data_d   = digit_data_q;
    decode_mode_d  = decode_mode_q;
    intensity_d    = intensity_q;
    scan_limit_d   = scan_limit_q;
    shutdown_n_d   = shutdown_n_q;
    display_test_d = display_test_q;
    addr           = shift_q[11:8];
    data           = shift_q[7:0];
    digit_idx      = 3'(addr - 4'd1);

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[KEEP_BITS-2:0], mosi_s};
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (cs_rise) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
          frame_valid_d = 1'b1;
          frame_addr_d  = addr;
          frame_data_d  = data;
          case (addr)
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8: digit_data_d[{digit_idx, 3'b000} +: 8] = data;
            4'h9:    decode_mode_d  = data;
            4'hA:    intensity_d    = data[3:0];
            4'hB:    scan_limit_d   = data[2:0];
            4'hC:    shutdown_n_d   = data[0];
            4'hF:    display_test_d = data[0];
            default: ;
          endcase
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Time word: low nibble of each digit register.
  always_comb begin
    time_data = '0;
    for (int i = 0; i < 8; i++) begin
      time_data[i*4 +: 4] = digit_data_q[i*8 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cs_sync_q      <= '1;
      sclk_sync_q    <= '0;
      mosi_sync_q    <= '0;
      vld_q          <= '0;
      cs_prev_q      <= 1'b1;
      sclk_prev_q    <= 1'b0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      frame_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
      frame_addr_q   <= '0;
      frame_data_q   <= '0;
      digit_data_q   <= '0;
      decode_mode_q  <= '0;
      intensity_q    <= '0;
      scan_limit_q   <= '0;
      shutdown_n_q   <= 1'b0;
      display_test_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cs_sync_q      <= cs_sync_d;
      sclk_sync_q    <= sclk_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      vld_q          <= vld_d;
      cs_prev_q      <= cs_prev_d;
      sclk_prev_q    <= sclk_prev_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      frame_valid_q  <= frame_valid_d;
      frame_err_q    <= frame_err_d;
      frame_addr_q   <= frame_addr_d;
      frame_data_q   <= frame_data_d;
      digit_data_q   <= digit_data_d;
      decode_mode_q  <= decode_mode_d;
      intensity_q    <= intensity_d;
      scan_limit_q   <= scan_limit_d;
      shutdown_n_q   <= shutdown_n_d;
      display_test_q <= display_test_d;
    end
  end

  assign frame_valid  = frame_valid_q;
  assign frame_err    = frame_err_q;
  assign frame_addr   = frame_addr_q;
  assign frame_data   = frame_data_q;
  assign digit_data   = digit_data_q;
  assign decode_mode  = decode_mode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_limit_q;
  assign shutdown_n   = shutdown_n_q;
  assign display_test = display_test_q;

endmodule

// File: tb/tb_max7219_rx.sv
// tb_max7219_rx: drives MAX7219 frames into max7219_rx and checks the frame
// pulses and shadow registers against a reference register model.
module tb_max7219_rx;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 4;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst, spi_cs_n, spi_sclk, spi_mosi;
  logic        frame_valid, frame_err;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;
  logic [63:0] digit_data;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n, display_test;
  logic [31:0] time_data;

  max7219_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .frame_valid(frame_valid), .frame_err(frame_err),
    .frame_addr(frame_addr), .frame_data(frame_data), .digit_data(digit_data),
    .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .shutdown_n(shutdown_n), .display_test(display_test), .time_data(time_data)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        v;
    logic        e;
    logic [3:0]  a;
    logic [7:0]  d;
    logic [63:0] dig;
    logic [7:0]  dm;
    logic [3:0]  inten;
    logic [2:0]  sl;
    logic        sd;
    logic        dt;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    int unsigned n;
    logic        good;
    logic        lat;
  } vec_t;

  exp_t sb[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;
  int   vcnt = 0, ecnt = 0;
  int   exp_vcnt = 0, exp_ecnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tword(input logic [63:0] dg);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = dg[i*8 +: 4];
    return r;
  endfunction

  task automatic model_reset();
    m.v = 1'b0; m.e = 1'b0; m.a = '0; m.d = '0; m.dig = '0;
    m.dm = '0; m.inten = '0; m.sl = '0; m.sd = 1'b0; m.dt = 1'b0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    m.a = a;
    m.d = d;
    case (a)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: m.dig[(int'(a)-1)*8 +: 8] = d;
      4'h9: m.dm = d;
      4'hA: m.inten = d[3:0];
      4'hB: m.sl = d[2:0];
      4'hC: m.sd = d[0];
      4'hF: m.dt = d[0];
      default: ;
    endcase
  endtask

  // Scoreboard consumer: every frame pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (frame_valid) vcnt++;
    if (frame_err) ecnt++;
    if (frame_valid || frame_err) begin
      chk("pulse_exclusive", 64'(frame_valid & frame_err), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'({frame_valid, frame_err}), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("frame_valid", 64'(frame_valid), 64'(e.v));
        chk("frame_err", 64'(frame_err), 64'(e.e));
        chk("frame_addr", 64'(frame_addr), 64'(e.a));
        chk("frame_data", 64'(frame_data), 64'(e.d));
        chk("digit_data", digit_data, e.dig);
        chk("decode_mode", 64'(decode_mode), 64'(e.dm));
        chk("intensity", 64'(intensity), 64'(e.inten));
        chk("scan_limit", 64'(scan_limit), 64'(e.sl));
        chk("shutdown_n", 64'(shutdown_n), 64'(e.sd));
        chk("display_test", 64'(display_test), 64'(e.dt));
        chk("time_data", 64'(time_data), 64'(tword(e.dig)));
      end
    end
  end

  task automatic send_bits(input logic [31:0] w, input int unsigned n);
    for (int i = int'(n) - 1; i >= 0; i--) begin
      spi_mosi = w[i];
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic wait_sb();
    for (int t = 0; t < 60; t++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic send_frame(input logic [31:0] w, input int unsigned n,
                            input logic good, input logic lat);
    exp_t e;
    if (good) begin
      model_write(w[11:8], w[7:0]);
      exp_vcnt++;
    end else begin
      exp_ecnt++;
    end
    e = m;
    e.v = good;
    e.e = ~good;
    sb.push_back(e);
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(w, n);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    if (lat) begin
      for (int k = 1; k <= int'(SYNC) + 2; k++) begin
        @(posedge clk);
        #1;
        chk($sformatf("latency_edge%0d", k), 64'(frame_valid),
            64'(k == int'(SYNC) + 2));
      end
    end
    wait_sb();
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int   v0, e0;

    vecs = '{
      '{32'h0105, 16, 1'b1, 1'b0}, '{32'h0209, 16, 1'b1, 1'b0},
      '{32'h0300, 16, 1'b1, 1'b0}, '{32'h0400, 16, 1'b1, 1'b0},
      '{32'h0500, 16, 1'b1, 1'b0}, '{32'h0600, 16, 1'b1, 1'b0},
      '{32'h0701, 16, 1'b1, 1'b0}, '{32'h0812, 16, 1'b1, 1'b0},
      '{32'h0355, 15, 1'b0, 1'b0},   // short frame
      '{32'h10466, 17, 1'b0, 1'b0},  // long frame
      '{32'h0A0F, 16, 1'b1, 1'b1},   // good frame right after, with latency check
      '{32'h0955, 16, 1'b1, 1'b0}
    };

    model_reset();
    rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_frame_addr", 64'(frame_addr), 64'd0);
    chk("rst_digit_data", digit_data, 64'd0);
    chk("rst_regs", 64'({decode_mode, intensity, scan_limit, shutdown_n, display_test}), 64'd0);
    chk("rst_time_data", 64'(time_data), 64'd0);

    // Power-up frame.
    send_frame(32'h0C01, 16, 1'b1, 1'b0);
    chk("t1_shutdown_n", 64'(shutdown_n), 64'd1);
    chk("t1_frame_addr", 64'(frame_addr), 64'hC);
    chk("t1_frame_data", 64'(frame_data), 64'h01);

    // Digit frames, short/long rejects, then intensity.
    for (int i = 0; i < 12; i++) begin
      send_frame(vecs[i].w, vecs[i].n, vecs[i].good, vecs[i].lat);
      if (i == 7) begin
        chk("t2_time_data", 64'(time_data), 64'h21000095);
        chk("t2_digit_lo", 64'(digit_data[7:0]), 64'h05);
        chk("t2_digit_data", digit_data, 64'h1201000000000905);
      end
      if (i == 8) chk("t3_digit_data", digit_data, 64'h1201000000000905);
    end
    chk("t4_intensity", 64'(intensity), 64'hF);
    chk("t4_decode_mode", 64'(decode_mode), 64'h55);
    chk("t4_err_count", 64'(ecnt), 64'd2);
    chk("t4_valid_count", 64'(vcnt), 64'(exp_vcnt));

    // Reset in the middle of a frame: the remainder must be discarded.
    v0 = vcnt; e0 = ecnt;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(32'h0B, 8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t5_rst_intensity", 64'(intensity), 64'd0);
    chk("t5_rst_shutdown_n", 64'(shutdown_n), 64'd0);
    chk("t5_rst_digit_data", digit_data, 64'd0);
    send_bits(32'h07, 8);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_no_valid", 64'(vcnt - v0), 64'd0);
    chk("t5_no_err", 64'(ecnt - e0), 64'd0);
    send_frame(32'h0B07, 16, 1'b1, 1'b0);
    chk("t5_scan_limit", 64'(scan_limit), 64'd7);

    // sclk activity with cs_n high must be ignored.
    v0 = vcnt; e0 = ecnt;
    for (int i = 0; i < 10; i++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      spi_sclk = ~spi_sclk;
    end
    spi_sclk = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_idle_sclk_pulses", 64'((vcnt - v0) + (ecnt - e0)), 64'd0);
    send_frame(32'h0F01, 16, 1'b1, 1'b0);
    send_frame(32'h0D55, 16, 1'b1, 1'b0);
    chk("t6_display_test", 64'(display_test), 64'd1);
    chk("t6_frame_addr", 64'(frame_addr), 64'hD);
    chk("t6_frame_data", 64'(frame_data), 64'h55);
    chk("t6_scan_limit", 64'(scan_limit), 64'd7);
    chk("t6_digit_data", digit_data, 64'd0);
    chk("final_valid_count", 64'(vcnt), 64'(exp_vcnt));
    chk("final_err_count", 64'(ecnt), 64'(exp_ecnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
